// File: rtl/kgp_add_sequencer.sv
// Arbitrates two requesters and performs a wide add one 16-bit slice per
// cycle through a shared external combinational adder, least-significant first.
module kgp_add_sequencer #(
    parameter int SLICES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   req0_valid,
    output logic                   req0_ready,
    input  logic [16*SLICES-1:0]   req0_a,
    input  logic [16*SLICES-1:0]   req0_b,
    input  logic                   req0_cin,
    input  logic                   req1_valid,
    output logic                   req1_ready,
    input  logic [16*SLICES-1:0]   req1_a,
    input  logic [16*SLICES-1:0]   req1_b,
    input  logic                   req1_cin,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic                   rsp_id,
    output logic [16*SLICES-1:0]   rsp_sum,
    output logic                   rsp_cout,
    output logic [15:0]            add_a,
    output logic [15:0]            add_b,
    output logic                   add_cin,
    input  logic [16:0]            add_y
);

    localparam int W  = 16 * SLICES;
    localparam int KW = (SLICES > 1) ? $clog2(SLICES) : 1;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t          state;
    logic [KW-1:0]   k;
    logic            carry;
    logic            last_grant;
    logic            id_q;
    logic            cin_q;
    logic [W-1:0]    a_q;
    logic [W-1:0]    b_q;
    logic            grant_any;
    logic            grant;

    // On a tie the requester that did not win last time is chosen.
    always_comb begin
        grant_any  = req0_valid | req1_valid;
        grant      = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
        req0_ready = rst_n & (state == IDLE) & grant_any & ~grant;
        req1_ready = rst_n & (state == IDLE) & grant_any & grant;
    end

    always_comb begin
        add_a   = '0;
        add_b   = '0;
        add_cin = 1'b0;
        if (state == RUN) begin
            add_a   = a_q[16*k +: 16];
            add_b   = b_q[16*k +: 16];
            add_cin = (k == '0) ? cin_q : carry;
        end
    end

    // Operand capture: only observable through the RUN-gated adder bus.
    always_ff @(posedge clk) begin
        if (state == IDLE && grant_any) begin
            a_q   <= grant ? req1_a   : req0_a;
            b_q   <= grant ? req1_b   : req0_b;
            cin_q <= grant ? req1_cin : req0_cin;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            k          <= '0;
            carry      <= 1'b0;
            last_grant <= 1'b1;
            id_q       <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_id     <= 1'b0;
            rsp_sum    <= '0;
            rsp_cout   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_any) begin
                        id_q       <= grant;
                        last_grant <= grant;
                        k          <= '0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    rsp_sum[16*k +: 16] <= add_y[15:0];
                    carry               <= add_y[16];
                    k                   <= k + 1'b1;
                    if (k == KW'(SLICES - 1)) begin
                        k         <= '0;
                        rsp_cout  <= add_y[16];
                        rsp_id    <= id_q;
                        rsp_valid <= 1'b1;
                        state     <= DONE;
                    end
                end
                DONE: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/kgp_add_sequencer.md
KGP_ADD_SEQUENCER -- requirements
Module: kgp_add_sequencer

Interface
REQ-001 SHALL have parameter SLICES, default 4: number of 16-bit slices per operation; operand width is 16*SLICES.
REQ-002 SHALL have port clk, input, 1: sole clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 SHALL have ports req0_valid/req1_valid, input, 1 each: requester n has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready, output, 1 each: operation accepted on a clk edge where valid and ready are both 1.
REQ-006 SHALL have ports req0_a/req0_b/req1_a/req1_b, input, 16*SLICES each: operands.
REQ-007 SHALL have ports req0_cin/req1_cin, input, 1 each: carry-in of the operation.
REQ-008 SHALL have ports rsp_valid (output, 1), rsp_ready (input, 1), rsp_id (output, 1, requester index), rsp_sum (output, 16*SLICES), rsp_cout (output, 1).
REQ-009 SHALL have ports add_a/add_b, output, 16 each, and add_cin, output, 1: operands and carry-in driven to the shared external combinational 16-bit KGP adder.
REQ-010 SHALL have port add_y, input, 17: adder result; add_y[15:0] is the sum, add_y[16] the carry-out.

Function
REQ-011 SHALL implement FSM states IDLE, RUN, DONE.
REQ-012 In IDLE, SHALL assert ready only to the granted requester: the one valid requester, or, when both are valid, the requester not granted last.
REQ-013 req0_ready/req1_ready SHALL be 0 in RUN and DONE and SHALL never be 1 simultaneously.
REQ-014 On acceptance, SHALL capture a, b, cin and the requester index, clear slice counter k to 0, and go to RUN.
REQ-015 In RUN, SHALL drive add_a/add_b with slice k (bits 16k+15:16k) of the captured operands.
REQ-016 In RUN, SHALL drive add_cin with the captured cin when k=0, otherwise with the carry register.
REQ-017 On each RUN edge, SHALL store add_y[15:0] into rsp_sum slice k, load add_y[16] into the carry register, and increment k.
REQ-018 On the RUN edge with k=SLICES-1, SHALL load rsp_cout with add_y[16], load rsp_id, assert rsp_valid, and go to DONE.
REQ-019 rsp_valid SHALL rise exactly SLICES cycles after the acceptance edge.
REQ-020 In DONE, rsp_valid, rsp_id, rsp_sum and rsp_cout SHALL hold stable until an edge with rsp_ready=1.
REQ-021 On that edge, SHALL deassert rsp_valid and go to IDLE, with a minimum of SLICES+2 cycles per operation.
REQ-022 add_a, add_b and add_cin SHALL be 0 whenever the state is not RUN.
REQ-023 The last-grant pointer SHALL update only on acceptance.
REQ-024 A requester dropping valid before acceptance SHALL cause no state change.
REQ-025 Sum arithmetic SHALL be modulo 2^(16*SLICES), with overflow reported only via rsp_cout.

Reset
REQ-026 When rst_n=0, SHALL immediately force the state to IDLE; k, the carry register, rsp_valid, rsp_id, rsp_sum, rsp_cout, add_a, add_b and add_cin to 0; and the last-grant pointer to 1, so that req0 wins the first tie.
REQ-027 Reset during RUN or DONE SHALL abort the operation and emit no response.
REQ-028 After rst_n rises, SHALL be able to accept a request on the first clk edge.

Verification
REQ-029 Ripple across slices: req0 a=0x0000_0000_0000_FFFF, b=0x1, cin=0 -> rsp_sum=0x0000_0000_0001_0000, rsp_cout=0, rsp_id=0; rsp_valid rises 4 cycles after acceptance.
REQ-030 Full carry chain: req1 a=0xFFFF_FFFF_FFFF_FFFF, b=0, cin=1 -> rsp_sum=0, rsp_cout=1, rsp_id=1.
REQ-031 Tie and round-robin: both valid from reset with rsp_ready=1 -> req0 served first, then req1, then req0; acceptances are spaced 6 cycles apart.
REQ-032 Backpressure: rsp_ready=0 for 5 cycles in DONE -> response fields stable, both ready signals 0, no add_* activity.
REQ-033 Reset mid-operation: rst_n=0 at k=2 -> all outputs 0 immediately; no rsp_valid; the next request completes correctly.
REQ-034 Adder bus: in IDLE/DONE add_a=add_b=0 and add_cin=0; in RUN the slices appear in order k=0..3.
